ov7670_capture: RTL and testbench
=================================

Name: ov7670_capture

Overview:
- Pixel capture stage directly downstream of the OV7670 SCCB configuration/control block.
- Oversamples the camera's PCLK/HREF/VSYNC/D[7:0] in the system clock domain and assembles byte pairs into RGB565 pixels.
- Writes each pixel, with a linear address, into the frame-buffer BRAM write port.
- Reports frame start, frame done and geometry errors to the display/control logic.

Parameters:
- H_PIXELS, 320, active pixels per line (QVGA).
- V_LINES, 240, active lines per frame.
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  capture enable from the control block; asserted once SCCB configuration is complete.
- i_ov7670_pclk  in  1  camera pixel clock, asynchronous.
- i_ov7670_vsync  in  1  camera VSYNC, asynchronous; high = vertical blank.
- i_ov7670_href  in  1  camera HREF, asynchronous; high = active bytes.
- i_ov7670_data  in  8  camera data, asynchronous.
- o_pix_wren  out  1  frame-buffer write strobe, 1-cycle pulse per pixel.
- o_pix_addr  out  ADDR_W  write address, valid while o_pix_wren=1.
- o_pix_data  out  16  RGB565 pixel {first byte, second byte}, valid while o_pix_wren=1.
- o_frame_start  out  1  1-cycle pulse at start of an active frame.
- o_frame_done  out  1  1-cycle pulse at end of frame.
- o_frame_err  out  1  sticky geometry error for the current/last frame.
- o_line_cnt  out  9  completed lines in the current frame.
- o_busy  out  1  high while in CAPTURE.

Behaviour:
- Reset is synchronous and active-high. On i_rst=1 the block returns to IDLE within the same edge and all outputs are 0: wren, addr, data, start, done, err, line_cnt, busy. Byte phase, synchronisers and the edge-history register are also cleared. Reset mid-frame abandons the frame silently.
- Synchronisation: PCLK, HREF, VSYNC and DATA each pass through identical 2-FF synchronisers, followed by one history FF for edge detection.
  - pclk_rise = s2 & ~s3. vs_rise and vs_fall are derived the same way; href_fall is also derived.
  - Requirement on the camera: PCLK high and low each >= 2 i_clk periods (PCLK <= 25 MHz).
- Latency: o_pix_wren pulses exactly 3 i_clk cycles after the first i_clk edge that samples the second byte's PCLK high. o_pix_addr and o_pix_data are registered with it.
- FSM states:
  - IDLE: wait for i_enable=1, then go to WAIT_FRAME.
  - WAIT_FRAME: wait for vs_fall. Any partial frame already in progress is ignored. On vs_fall:
    - addr = 0, phase = 0, line_cnt = 0, err = 0;
    - pulse o_frame_start;
    - go to CAPTURE.
  - CAPTURE (o_busy=1), on pclk_rise with synchronised HREF=1:
    - phase 0: latch the byte as hi, phase <= 1.
    - phase 1: o_pix_data = {hi, byte}, o_pix_wren = 1, o_pix_addr = addr, addr <= addr+1, phase <= 0.
  - CAPTURE, on href_fall:
    - if phase=1 (odd byte count), err <= 1;
    - phase <= 0, line_cnt <= line_cnt+1.
  - CAPTURE, on vs_rise:
    - pulse o_frame_done;
    - err <= 1 if addr != H_PIXELS*V_LINES or line_cnt != V_LINES. The line_cnt compare uses the value including any href_fall in the same cycle.
    - go to WAIT_FRAME if i_enable=1, else IDLE.
- Overflow: if a pixel completes when addr = H_PIXELS*V_LINES, the write is suppressed (no wren), addr holds and err <= 1. Addresses never wrap.
- i_enable deassert mid-frame: the current frame completes normally; the enable is evaluated only at vs_rise and in IDLE/WAIT_FRAME. In WAIT_FRAME, i_enable=0 returns to IDLE.
- o_frame_err is sticky from the error until the next o_frame_start.
- Simultaneous events:
  - href_fall and pclk_rise in the same cycle: the pixel write is processed first, then the line-end rules.
  - vs_rise with href_fall in the same cycle: the line is counted before the frame check.

Decomposition:
- Shared package ov7670_pkg holds:
  - capture FSM state encoding (IDLE, WAIT_FRAME, CAPTURE);
  - QVGA/VGA geometry constants;
  - the OV7670 SCCB addresses 8'h42/8'h43 used by the control block.
- One sub-module, sync_edge: a parameterless 1-bit 2-FF synchroniser plus history FF. Outputs are level, rise and fall. It is instantiated for PCLK, HREF and VSYNC. DATA uses a plain 8-bit 2-FF bank matched in depth.

Test Plan:
- Full frame: i_enable=1, 8 MHz PCLK, 320x240 with bytes i, i+1 -> 76800 wrens; first {8'h00,8'h01} at addr 0; last at addr 76799; o_frame_done once; o_frame_err=0; o_line_cnt=240.
- Latency: single byte pair 8'hA5,8'h5A -> o_pix_wren exactly 3 cycles after PCLK sampled high; o_pix_data=16'hA55A.
- Odd byte line: line 5 has 641 bytes -> err=1 after line 5 href_fall; the next line starts at phase 0; err clears at the next frame start.
- Overflow: 241 lines -> writes after addr 76799 are suppressed, no wrap to 0, err=1 at frame done.
- Mid-frame start: enable asserted during line 100 -> no writes until the next vs_fall; the next frame is captured complete from addr 0.
- Reset mid-frame: i_rst=1 for 1 cycle at pixel 1000 -> all outputs 0 next cycle; IDLE; capture resumes only after the next full vs_fall.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 camera path: capture FSM encoding,
// frame geometry and the SCCB device addresses used by the control block.
package ov7670_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2
    } cap_state_t;

    localparam int QVGA_H = 320;
    localparam int QVGA_V = 240;
    localparam int VGA_H  = 640;
    localparam int VGA_V  = 480;

    localparam logic [7:0] SCCB_WR_ADDR = 8'h42;
    localparam logic [7:0] SCCB_RD_ADDR = 8'h43;

    function automatic int frame_pixels(input int h, input int v);
        return h * v;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// 1-bit two-flop synchroniser followed by a history flop for edge detection.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/ov7670_capture.sv
// Oversampled OV7670 capture: pairs camera bytes into RGB565 pixels and
// writes them with linear addresses into the frame-buffer write port.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_PIXELS = QVGA_H,
    parameter int V_LINES  = QVGA_V,
    parameter int ADDR_W   = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_ov7670_pclk,
    input  logic              i_ov7670_vsync,
    input  logic              i_ov7670_href,
    input  logic [7:0]        i_ov7670_data,
    output logic              o_pix_wren,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [15:0]       o_pix_data,
    output logic              o_frame_start,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic [8:0]        o_line_cnt,
    output logic              o_busy
);
    localparam int                FRAME_PIX = frame_pixels(H_PIXELS, V_LINES);
    localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(FRAME_PIX);
    localparam logic [8:0]        LINE_END  = 9'(V_LINES);

    logic w_pclk_lvl, w_pclk_rise, w_pclk_fall;
    logic w_href_lvl, w_href_rise, w_href_fall;
    logic w_vs_lvl, w_vs_rise, w_vs_fall;

    sync_edge u_sync_pclk (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_ov7670_pclk),
                           .o_level(w_pclk_lvl), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall));
    sync_edge u_sync_href (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_ov7670_href),
                           .o_level(w_href_lvl), .o_rise(w_href_rise), .o_fall(w_href_fall));
    sync_edge u_sync_vs   (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_ov7670_vsync),
                           .o_level(w_vs_lvl), .o_rise(w_vs_rise), .o_fall(w_vs_fall));

    logic w_unused;
    assign w_unused = &{1'b0, w_pclk_lvl, w_pclk_fall, w_href_rise, w_vs_lvl};

    // Data bank is two flops deep so bytes line up with the synchronised PCLK level.
    logic [7:0] r_d_s1, r_d_s2;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d_s1 <= '0;
            r_d_s2 <= '0;
        end else begin
            r_d_s1 <= i_ov7670_data;
            r_d_s2 <= r_d_s1;
        end
    end

    cap_state_t        r_state;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_line_cnt;
    logic              r_err, r_start, r_done;
    logic              r_wr_req;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;

    logic              w_byte_stb, w_pix_done, w_ovf, w_phase_pix, w_geom_bad;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [8:0]        w_line_nxt;

    // Pixel effects are resolved first; line-end and frame-end checks see the result.
    assign w_byte_stb  = w_pclk_rise & w_href_lvl;
    assign w_pix_done  = w_byte_stb & r_phase;
    assign w_ovf       = w_pix_done & (r_addr == ADDR_END);
    assign w_addr_nxt  = (w_pix_done & ~w_ovf) ? r_addr + ADDR_W'(1) : r_addr;
    assign w_phase_pix = w_byte_stb ? ~r_phase : r_phase;
    assign w_line_nxt  = w_href_fall ? r_line_cnt + 9'd1 : r_line_cnt;
    assign w_geom_bad  = (w_addr_nxt != ADDR_END) | (w_line_nxt != LINE_END);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= 1'b0;
            r_hi       <= '0;
            r_addr     <= '0;
            r_line_cnt <= '0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_wr_req   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_wr_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) r_state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (!i_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_vs_fall) begin
                        r_addr     <= '0;
                        r_phase    <= 1'b0;
                        r_line_cnt <= '0;
                        r_err      <= 1'b0;
                        r_start    <= 1'b1;
                        r_state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_byte_stb) begin
                        if (!r_phase) begin
                            r_hi <= r_d_s2;
                        end else if (!w_ovf) begin
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= {r_hi, r_d_s2};
                        end
                    end
                    r_addr     <= w_addr_nxt;
                    r_phase    <= w_href_fall ? 1'b0 : w_phase_pix;
                    r_line_cnt <= w_line_nxt;
                    if (w_ovf || (w_href_fall && w_phase_pix) || (w_vs_rise && w_geom_bad))
                        r_err <= 1'b1;
                    if (w_vs_rise) begin
                        r_done  <= 1'b1;
                        r_state <= i_enable ? ST_WAIT_FRAME : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write port output stage.
    logic              r_pix_wren;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [15:0]       r_pix_data;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_wren <= 1'b0;
            r_pix_addr <= '0;
            r_pix_data <= '0;
        end else begin
            r_pix_wren <= r_wr_req;
            r_pix_addr <= r_wr_addr;
            r_pix_data <= r_wr_data;
        end
    end

    assign o_pix_wren    = r_pix_wren;
    assign o_pix_addr    = r_pix_addr;
    assign o_pix_data    = r_pix_data;
    assign o_frame_start = r_start;
    assign o_frame_done  = r_done;
    assign o_frame_err   = r_err;
    assign o_line_cnt    = r_line_cnt;
    assign o_busy        = (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 6x4 geometry, with a
// byte-pairing reference model and a per-cycle write scoreboard.
module tb_ov7670_capture;
    localparam int H = 6;
    localparam int V = 4;
    localparam int AW = 5;
    localparam int TOTAL = H * V;
    localparam int LB = 2 * H;

    logic clk = 1'b0;
    logic rst, en, pclk, vsync, href;
    logic [7:0] data;
    logic wren, fstart, fdone, ferr, busy;
    logic [AW-1:0] addr;
    logic [15:0] pdata;
    logic [8:0] lcnt;

    always #5 clk = ~clk;

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_ov7670_pclk(pclk), .i_ov7670_vsync(vsync), .i_ov7670_href(href),
        .i_ov7670_data(data),
        .o_pix_wren(wren), .o_pix_addr(addr), .o_pix_data(pdata),
        .o_frame_start(fstart), .o_frame_done(fdone), .o_frame_err(ferr),
        .o_line_cnt(lcnt), .o_busy(busy)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int n_chk = 0, n_err = 0;
    int n_wr = 0, n_start = 0, n_done = 0;
    int first_addr = 0, first_data = 0, last_addr = 0, last_data = 0;
    logic m_cap = 1'b0, m_phase = 1'b0;
    logic [7:0] m_hi = 8'h00, m_byte = 8'h00;
    int m_addr = 0;
    int s_start, s_done;

    task automatic check(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wren"},  wren,   0);
        check({tag, "_addr"},  addr,   0);
        check({tag, "_data"},  pdata,  0);
        check({tag, "_start"}, fstart, 0);
        check({tag, "_done"},  fdone,  0);
        check({tag, "_err"},   ferr,   0);
        check({tag, "_lcnt"},  lcnt,   0);
        check({tag, "_busy"},  busy,   0);
    endtask

    // Write scoreboard and pulse counters, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (fstart) n_start++;
        if (fdone) n_done++;
        if (wren) begin
            if (n_wr == 0) begin
                first_addr = addr;
                first_data = pdata;
            end
            n_wr++;
            last_addr = addr;
            last_data = pdata;
            check("wr_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", addr, e.a);
                check("wr_data", pdata, e.d);
            end
        end
    end

    // Reference: bytes pair up within a line, pixels fill addresses from 0 up to TOTAL-1.
    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        if (!m_phase) begin
            m_hi = b;
        end else if (m_cap && m_addr < TOTAL) begin
            w.a = AW'(m_addr);
            w.d = {m_hi, b};
            exp_q.push_back(w);
            m_addr++;
        end
        m_phase = ~m_phase;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        pclk = 1'b0; data = b; href = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bytes(input int n);
        for (int j = 0; j < n; j++) begin
            model_byte(m_byte);
            drive_byte(m_byte);
            m_byte = m_byte + 8'd1;
        end
    endtask

    task automatic end_line();
        @(negedge clk);
        pclk = 1'b0; href = 1'b0;
        m_phase = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_line(input int n);
        send_bytes(n);
        end_line();
    endtask

    task automatic frame_begin();
        @(negedge clk);
        vsync = 1'b1;
        repeat (8) @(negedge clk);
        m_cap = en; m_addr = 0; m_phase = 1'b0; m_byte = 8'h00; n_wr = 0;
        vsync = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        vsync = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic full_frame(input string tag);
        s_start = n_start; s_done = n_done;
        frame_begin();
        check({tag, "_start"}, n_start, s_start + 1);
        check({tag, "_busy"}, busy, 1);
        repeat (V) send_line(LB);
        frame_end();
        check({tag, "_done"}, n_done, s_done + 1);
        check({tag, "_err"}, ferr, 0);
        check({tag, "_lcnt"}, lcnt, V);
        check({tag, "_nwr"}, n_wr, TOTAL);
        check({tag, "_first_addr"}, first_addr, 0);
        check({tag, "_first_data"}, first_data, 16'h0001);
        check({tag, "_last_addr"}, last_addr, 23);
        check({tag, "_last_data"}, last_data, 16'h2E2F);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
        repeat (4) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Full frame with incrementing bytes.
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("t1_wait_busy", busy, 0);
        full_frame("t1");

        // Latency of a single byte pair.
        frame_begin();
        model_byte(8'hA5);
        drive_byte(8'hA5);
        model_byte(8'h5A);
        @(negedge clk);
        pclk = 1'b0; data = 8'h5A; href = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        pclk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("lat_wren_c%0d", k), wren, int'(k == 4));
        end
        check("lat_data", pdata, 16'hA55A);
        check("lat_addr", addr, 0);
        end_line();
        frame_end();
        check("lat_err", ferr, 1);
        check("lat_lcnt", lcnt, 1);
        check("lat_q_empty", exp_q.size(), 0);

        // Odd byte count on line 1.
        frame_begin();
        check("odd_err_clr", ferr, 0);
        send_line(LB);
        send_line(LB + 1);
        check("odd_err_set", ferr, 1);
        check("odd_lcnt", lcnt, 2);
        send_line(LB);
        send_line(LB);
        frame_end();
        check("odd_err_end", ferr, 1);
        check("odd_nwr", n_wr, TOTAL);
        check("odd_last_addr", last_addr, TOTAL - 1);
        check("odd_lcnt_end", lcnt, V);
        check("odd_q_empty", exp_q.size(), 0);

        // One line too many: overflow writes suppressed.
        frame_begin();
        check("ovf_err_clr", ferr, 0);
        repeat (V) send_line(LB);
        check("ovf_err_pre", ferr, 0);
        send_line(LB);
        check("ovf_err_set", ferr, 1);
        frame_end();
        check("ovf_err_end", ferr, 1);
        check("ovf_nwr", n_wr, TOTAL);
        check("ovf_last_addr", last_addr, TOTAL - 1);
        check("ovf_lcnt", lcnt, V + 1);
        check("ovf_q_empty", exp_q.size(), 0);

        // Enable arrives mid-frame: that frame is skipped, the next is captured.
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_idle_busy", busy, 0);
        s_start = n_start; s_done = n_done;
        frame_begin();
        send_line(LB);
        send_line(LB);
        send_bytes(H);
        en = 1'b1;
        send_bytes(H);
        end_line();
        send_line(LB);
        frame_end();
        check("mid_nwr", n_wr, 0);
        check("mid_nstart", n_start, s_start);
        check("mid_ndone", n_done, s_done);
        full_frame("mid_next");

        // Reset in the middle of line 1, pixel 8.
        s_done = n_done;
        frame_begin();
        send_line(LB);
        send_bytes(4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        m_cap = 1'b0;
        @(negedge clk);
        check_zero("mrst");
        rst = 1'b0;
        check("mrst_nwr", n_wr, H + 2);
        send_bytes(LB - 4);
        end_line();
        send_line(LB);
        send_line(LB);
        frame_end();
        check("mrst_nwr_end", n_wr, H + 2);
        check("mrst_ndone", n_done, s_done);
        check("mrst_busy", busy, 0);
        full_frame("mrst_next");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
